// File: rtl/spi_cmd_sequencer.sv
// Command FIFO feeding a single-outstanding SPI master handshake, with a one-entry response register.
// Optional transfer timeout is compiled in with `define SPI_SEQ_TIMEOUT_EN.
module spi_cmd_sequencer #(
  parameter int unsigned DEPTH          = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  input  logic [5:0]  cmd_nbits,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        spi_request,
  output logic [31:0] spi_mosi_data,
  output logic [5:0]  spi_nbits,
  input  logic        spi_ready,
  input  logic [31:0] spi_miso_data,
  output logic        busy,
  output logic [4:0]  level
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [4:0]  DEPTH_L = 5'(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 32'd0) begin : g_bad_params
    $error("spi_cmd_sequencer: DEPTH must be a power of two in 2..16 and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, STORE} state_t;

  state_t        state, state_nxt;
  logic [37:0]   fifo_mem [DEPTH];
  logic [37:0]   fifo_head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, load_rsp;
  logic          tmo_hit;

  assign cmd_ready   = (level != DEPTH_L);
  assign push        = cmd_valid && cmd_ready;
  assign fifo_head   = fifo_mem[rd_ptr];
  assign spi_request = (state == ISSUE);
  assign busy        = (state != IDLE) || (level != 5'd0);

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        timed_out;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      tmo_cnt   <= '0;
      timed_out <= 1'b0;
    end else begin
      unique case (state)
        ISSUE: begin
          tmo_cnt   <= '0;
          timed_out <= 1'b0;
        end
        WAIT_LOW, WAIT_HIGH: begin
          tmo_cnt <= tmo_cnt + 32'd1;
          if (tmo_hit) timed_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tmo_hit = ((state == WAIT_LOW) || (state == WAIT_HIGH)) &&
                   (tmo_cnt >= TIMEOUT_CYCLES - 32'd1);
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_rsp  = 1'b0;
    unique case (state)
      IDLE: begin
        if (level != 5'd0) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:     state_nxt = WAIT_LOW;
      // Ready is sticky from the previous transfer; see it fall before trusting a rise.
      WAIT_LOW:  if (!spi_ready) state_nxt = WAIT_HIGH;
      WAIT_HIGH: if (spi_ready)  state_nxt = STORE;
      STORE: begin
        if (!rsp_valid || rsp_ready) begin
          load_rsp  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default:   state_nxt = IDLE;
    endcase
    if (tmo_hit) state_nxt = STORE;
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_nbits, cmd_data};
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      spi_mosi_data <= '0;
      spi_nbits     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr        <= rd_ptr + AW'(1);
        spi_mosi_data <= fifo_head[31:0];
        spi_nbits     <= fifo_head[37:32];
      end
      unique case ({push, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
      rsp_err   <= 1'b0;
`endif
    end else if (load_rsp) begin
      rsp_valid <= 1'b1;
`ifdef SPI_SEQ_TIMEOUT_EN
      rsp_data  <= timed_out ? 32'd0 : spi_miso_data;
      rsp_err   <= timed_out;
`else
      rsp_data  <= spi_miso_data;
`endif
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer with a loopback SPI master model (MISO = last MOSI word).
module tb_spi_cmd_sequencer;

  localparam int unsigned DEPTH = 4;
`ifdef SPI_SEQ_TIMEOUT_EN
  localparam logic [31:0] TMO = 32'd16;
`else
  localparam logic [31:0] TMO = 32'd1000000;
`endif

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_data = '0;
  logic [5:0]  cmd_nbits = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        spi_request;
  logic [31:0] spi_mosi_data;
  logic [5:0]  spi_nbits;
  logic        spi_ready = 1'b0;
  logic [31:0] spi_miso_data = '0;
  logic        busy;
  logic [4:0]  level;

  spi_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk_in), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_nbits(cmd_nbits),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .spi_request(spi_request), .spi_mosi_data(spi_mosi_data), .spi_nbits(spi_nbits),
    .spi_ready(spi_ready), .spi_miso_data(spi_miso_data),
    .busy(busy), .level(level)
  );

  always #5 clk_in = ~clk_in;

  // SPI master model: ready drops on request, rises (sticky) 3 cycles later unless stalled.
  logic        m_stall = 1'b0;
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_data = '0;

  always @(posedge clk_in) begin
    if (spi_request) begin
      spi_ready <= 1'b0;
      m_busy    <= 1'b1;
      m_cnt     <= 2;
      m_data    <= spi_mosi_data;
    end else if (m_busy && !m_stall) begin
      if (m_cnt == 0) begin
        spi_ready     <= 1'b1;
        spi_miso_data <= m_data;
        m_busy        <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  int         req_cnt = 0;
  logic [4:0] max_level = '0;
  always @(negedge clk_in) begin
    if (spi_request) req_cnt <= req_cnt + 1;
    if (level > max_level) max_level <= level;
  end

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
  endtask

  task automatic push(input logic [31:0] d, input logic [5:0] nb);
    for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk_in);
    if (!cmd_ready) begin
      check("push_ready_timeout", {31'd0, cmd_ready}, 32'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_nbits = nb;
    @(negedge clk_in);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 300 && !rsp_valid; i++) @(negedge clk_in);
  endtask

  task automatic wait_rsp(input string name, input logic [31:0] exp_d, input logic exp_e);
    wait_valid();
    check({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    if (rsp_valid) begin
      check({name, "_data"}, rsp_data, exp_d);
      check({name, "_err"}, {31'd0, rsp_err}, {31'd0, exp_e});
      rsp_ready = 1'b1;
      @(negedge clk_in);
      rsp_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [5:0]  nbits;
    logic [31:0] exp_rsp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int accepted, bad, rc, n;
    logic go;

    vecs[0] = '{32'h0000_0000, 6'd0,  32'h0000_0000};
    vecs[1] = '{32'hFFFF_FFFF, 6'd63, 32'hFFFF_FFFF};
    vecs[2] = '{32'h1234_5678, 6'd31, 32'h1234_5678};
    vecs[3] = '{32'h0000_0001, 6'd0,  32'h0000_0001};
    vecs[4] = '{32'hDEAD_BEEF, 6'd15, 32'hDEAD_BEEF};
    vecs[5] = '{32'h8000_0000, 6'd32, 32'h8000_0000};

    repeat (3) @(negedge clk_in);
    check("rst_level", {27'd0, level}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_spi_request", {31'd0, spi_request}, 32'd0);
    check("rst_spi_mosi", spi_mosi_data, 32'd0);
    check("rst_spi_nbits", {26'd0, spi_nbits}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk_in);

    // Basic loopback transfer and request latency/pulse width.
    push(32'h0000_00A5, 6'd7);
    check("lat_no_req_yet", {31'd0, spi_request}, 32'd0);
    @(negedge clk_in);
    check("lat_req", {31'd0, spi_request}, 32'd1);
    check("req_mosi", spi_mosi_data, 32'h0000_00A5);
    check("req_nbits", {26'd0, spi_nbits}, 32'd7);
    @(negedge clk_in);
    check("req_one_cycle", {31'd0, spi_request}, 32'd0);
    wait_rsp("a5", 32'h0000_00A5, 1'b0);

    for (int i = 0; i < 6; i++) begin
      push(vecs[i].data, vecs[i].nbits);
      wait_rsp($sformatf("vec%0d", i), vecs[i].exp_rsp, 1'b0);
      check($sformatf("vec%0d_mosi_held", i), spi_mosi_data, vecs[i].data);
      check($sformatf("vec%0d_nbits_held", i), {26'd0, spi_nbits}, {26'd0, vecs[i].nbits});
    end

    // Fill with the master stalled: one command in flight plus DEPTH queued.
    m_stall = 1'b1;
    accepted = 0;
    for (int c = 0; c < 40 && accepted < 5; c++) begin
      cmd_valid = 1'b1;
      cmd_data  = 32'hC0DE_0000 + 32'(accepted);
      cmd_nbits = 6'd9;
      go = cmd_ready;
      @(negedge clk_in);
      if (go) accepted++;
    end
    cmd_valid = 1'b0;
    check("fill_accepted", 32'(accepted), 32'd5);
    check("fill_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("fill_level", {27'd0, level}, 32'd4);
    repeat (3) @(negedge clk_in);
    check("fill_level_hold", {27'd0, level}, 32'd4);
    m_stall = 1'b0;
    for (int k = 0; k < 5; k++)
      wait_rsp($sformatf("order%0d", k), 32'hC0DE_0000 + 32'(k), 1'b0);

    // Back-pressure on responses across two transfers.
    push(32'h0000_0111, 6'd3);
    push(32'h0000_0222, 6'd3);
    wait_valid();
    check("bp_first", rsp_data, 32'h0000_0111);
    bad = 0;
    repeat (15) begin
      @(negedge clk_in);
      if (rsp_data !== 32'h0000_0111 || rsp_valid !== 1'b1 || rsp_err !== 1'b0) bad++;
    end
    check("bp_hold_stable", 32'(bad), 32'd0);
    check("bp_busy_store", {31'd0, busy}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk_in);
    check("bp_second_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp_second_data", rsp_data, 32'h0000_0222);
    @(negedge clk_in);
    rsp_ready = 1'b0;
    check("bp_drained", {31'd0, rsp_valid}, 32'd0);

    // Reset while waiting for the master's ready.
    m_stall = 1'b1;
    push(32'h0000_0333, 6'd1);
    push(32'h0000_0444, 6'd1);
    repeat (6) @(negedge clk_in);
    check("mid_level", {27'd0, level}, 32'd1);
    rc = req_cnt;
    rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    check("mid_rst_level", {27'd0, level}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_request", {31'd0, spi_request}, 32'd0);
    m_stall = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk_in);
      if (rsp_valid !== 1'b0) bad++;
    end
    check("mid_rst_no_rsp", 32'(bad), 32'd0);
    check("mid_rst_no_req", 32'(req_cnt - rc), 32'd0);
    push(32'h0000_005A, 6'd7);
    wait_rsp("post_rst", 32'h0000_005A, 1'b0);

    // Simultaneous push and pop at level 2.
    m_stall = 1'b1;
    push(32'h0000_00A1, 6'd4);
    push(32'h0000_00B2, 6'd4);
    push(32'h0000_00C3, 6'd4);
    repeat (3) @(negedge clk_in);
    check("pp_level_before", {27'd0, level}, 32'd2);
    m_stall = 1'b0;
    wait_valid();
    check("pp_first", rsp_data, 32'h0000_00A1);
    check("pp_level_at_pop", {27'd0, level}, 32'd2);
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_data  = 32'h0000_00D4;
    cmd_nbits = 6'd4;
    @(negedge clk_in);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check("pp_level_after", {27'd0, level}, 32'd2);
    wait_rsp("pp_b", 32'h0000_00B2, 1'b0);
    wait_rsp("pp_c", 32'h0000_00C3, 1'b0);
    wait_rsp("pp_d", 32'h0000_00D4, 1'b0);

`ifdef SPI_SEQ_TIMEOUT_EN
    m_stall = 1'b1;
    push(32'h0000_0777, 6'd7);
    for (int i = 0; i < 50 && !spi_request; i++) @(negedge clk_in);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    check("tmo_valid", {31'd0, rsp_valid}, 32'd1);
    check("tmo_err", {31'd0, rsp_err}, 32'd1);
    check("tmo_data", rsp_data, 32'd0);
    check("tmo_latency_window", {31'd0, (n >= 14 && n <= 22)}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk_in);
    rsp_ready = 1'b0;
    m_stall = 1'b0;
    push(32'h0000_0888, 6'd7);
    wait_rsp("tmo_next", 32'h0000_0888, 1'b0);
`else
    n = 0;
`endif

    check("max_level", {27'd0, max_level}, 32'd4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, meaning command FIFO entries (power of two, 2..16).
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 32'd1000000, meaning clk_in cycles allowed per transfer when timeout is compiled in.
REQ-003 SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- clk_in  input  1  logic clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command FIFO not full.
- cmd_data  input  32  MOSI word, LSB-aligned.
- cmd_nbits  input  6  bits minus one (0 = 1 bit).
- rsp_valid  output  1  response held.
- rsp_ready  input  1  response consumed.
- rsp_data  output  32  MISO word, as returned by the SPI master.
- rsp_err  output  1  transfer timed out.
- spi_request  output  1  to SPI master request.
- spi_mosi_data  output  32  to SPI master mosi_data.
- spi_nbits  output  6  to SPI master nbits.
- spi_ready  input  1  from SPI master ready; sticky high after a transfer, low after reset.
- spi_miso_data  input  32  from SPI master miso_data.
- busy  output  1  state not IDLE or FIFO non-empty.
- level  output  5  FIFO occupancy, 0..DEPTH.

Function
REQ-004 SHALL accept a command when cmd_valid && cmd_ready, and store {cmd_nbits, cmd_data} in the FIFO.
REQ-005 SHALL drive cmd_ready = (level != DEPTH), so a push is refused when the FIFO is full, even if a pop occurs in the same cycle.
REQ-006 SHALL leave level unchanged on a simultaneous push and pop, with pointers wrapping modulo DEPTH.
REQ-007 SHALL implement the states IDLE, ISSUE, WAIT_LOW, WAIT_HIGH and STORE.
REQ-008 SHALL move IDLE->ISSUE when the FIFO is non-empty, popping the head into spi_mosi_data/spi_nbits, which are held stable until the next pop.
REQ-009 SHALL assert spi_request for exactly one cycle in ISSUE, then go to WAIT_LOW.
REQ-010 SHALL move WAIT_LOW->WAIT_HIGH when spi_ready==0, which absorbs the stale sticky ready from the previous transfer.
REQ-011 SHALL move WAIT_HIGH->STORE when spi_ready==1.
REQ-012 SHALL, in STORE, load rsp_data<=spi_miso_data, rsp_err<=0 and rsp_valid<=1, then go to IDLE, but only when !rsp_valid || rsp_ready; otherwise it holds STORE.
REQ-013 SHALL clear rsp_valid on rsp_valid && rsp_ready, unless a new load occurs in the same cycle, in which case it remains 1 with the new data.
REQ-014 SHALL give a minimum command-to-spi_request latency of 2 cycles (push edge, then IDLE->ISSUE edge).
REQ-015 SHALL keep rsp_data and rsp_err stable while rsp_valid && !rsp_ready.
REQ-016 SHALL issue transfers strictly in FIFO order, with at most one outstanding.

Reset
REQ-017 SHALL, while rst=1 at a clock edge, reset to: state IDLE, FIFO empty (level=0, cmd_ready=1), spi_request=0, spi_mosi_data=0, spi_nbits=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, and timeout counter 0.
REQ-018 SHALL, when rst is asserted mid-transfer, drop the in-flight command without generating a response; the SPI master is reset by its own nrst and is not reset by this block.

Configuration
REQ-019 SHALL include, when SPI_SEQ_TIMEOUT_EN is defined, a 32-bit counter that clears in ISSUE and increments in WAIT_LOW/WAIT_HIGH; on reaching TIMEOUT_CYCLES the block goes to STORE with rsp_data=0 and rsp_err=1.
REQ-020 SHALL, when SPI_SEQ_TIMEOUT_EN is not defined, contain no counter, tie rsp_err to 0, and wait in WAIT_LOW/WAIT_HIGH indefinitely.

Verification
REQ-021 SHALL cover: push {nbits=7, data=0xA5} with a master model looping MOSI to MISO -> one spi_request pulse, spi_mosi_data=0xA5, rsp_valid with rsp_data=0x000000A5, rsp_err=0.
REQ-022 SHALL cover: push 5 commands back-to-back with DEPTH=4 and the master stalled -> cmd_ready=0 after the 4th accept (or the 5th if one is popped), level never exceeds 4, and responses arrive in push order.
REQ-023 SHALL cover: hold rsp_ready=0 across two transfers -> the first response is held stable, the FSM waits in STORE, and the second response loads on the cycle rsp_ready=1.
REQ-024 SHALL cover: assert rst in WAIT_HIGH -> next cycle state IDLE, level=0, rsp_valid=0, no spurious spi_request.
REQ-025 SHALL cover: with SPI_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16 and spi_ready stuck low -> a response with rsp_err=1 and rsp_data=0 about 17 cycles after ISSUE; the next command is then issued.
REQ-026 SHALL cover: simultaneous push and pop at level=2 -> level stays 2 and the data order is preserved.
